// File: rtl/srudcs_pkg.sv
// Shared definitions for the SRU DCS command path: FSM encoding, command-word
// layout and the default timeout reply word.
package srudcs_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam int ADDR_WR_BIT  = 31;
   localparam int CMD_ADDR_LSB = 32;
   localparam int CMD_DATA_LSB = 0;
   localparam int CMD_FIELD_W  = 32;

   localparam logic [31:0] TMO_WORD_DEF = 32'hDEAD_0BAD;

   typedef struct packed {
      logic [CMD_FIELD_W-1:0] addr;
      logic [CMD_FIELD_W-1:0] data;
   } dcs_cmd_t;

endpackage

// File: rtl/srudcscmdfifo.sv
// Synchronous 2^QAW-deep command FIFO; full/empty come from the registered
// occupancy so they never depend on same-cycle push/pop.
module srudcscmdfifo #(
   parameter int QAW = 2,
   parameter int W   = 64
) (
   input  logic         dcsclk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   logic [W-1:0]   mem [2**QAW];
   logic [QAW-1:0] wp, rp;
   logic [QAW:0]   occ;
   logic           push_ok, pop_ok;

   assign full    = (occ == (QAW+1)'(2**QAW));
   assign empty   = (occ == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rp];

   always_ff @(posedge dcsclk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         occ <= '0;
      end else begin
         if (push_ok) wp <= wp + 1'b1;
         if (pop_ok)  rp <= rp + 1'b1;
         occ <= occ + (QAW+1)'(push_ok) - (QAW+1)'(pop_ok);
      end
   end

   always_ff @(posedge dcsclk) begin
      if (push_ok) mem[wp] <= wdata;
   end

endmodule

// File: rtl/srudcscmdissue.sv
// DCS command initiator: queues {addr,data} words, issues one at a time and
// waits for the executor reply. Timeout reply enabled by SRU_DCS_CMD_TIMEOUT_EN.
module srudcscmdissue
   import srudcs_pkg::*;
#(
   parameter int          QAW        = 2,
   parameter int          TMO_CYCLES = 4096,
   parameter logic [31:0] TMO_WORD   = TMO_WORD_DEF
) (
   input  logic        dcsclk,
   input  logic        reset,
   input  logic        dcs_cmd_dv,
   input  logic [63:0] dcs_cmd_word,
   output logic        dcs_cmd_full,
   output logic        dcs_cmd_ovf,
   output logic        rcmd_exec,
   output logic        rcmd_wr,
   output logic [31:0] rcmd_addr,
   output logic [31:0] rcmd_data,
   input  logic        rcmd_reply_dv,
   output logic [31:0] udp_cmd_addr,
   output logic        tmo_reply_dv,
   output logic [31:0] tmo_reply_data,
   output logic [15:0] cmd_cnt,
   output logic [7:0]  tmo_cnt
);

   logic [1:0]  state;
   logic        hold_first;
   dcs_cmd_t    cmd;
   logic [63:0] fifo_rdata;
   logic        fifo_empty, fifo_pop, tmo_hit;

   assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

   srudcscmdfifo #(.QAW(QAW), .W(64)) u_fifo (
      .dcsclk (dcsclk),
      .reset  (reset),
      .push   (dcs_cmd_dv),
      .wdata  (dcs_cmd_word),
      .pop    (fifo_pop),
      .rdata  (fifo_rdata),
      .full   (dcs_cmd_full),
      .empty  (fifo_empty)
   );

   // The command register is only reloaded on pop, so rcmd_*/udp_cmd_addr
   // stay frozen from ISSUE through the end of HOLD.
   assign rcmd_exec      = (state == ST_ISSUE);
   assign rcmd_wr        = cmd.addr[ADDR_WR_BIT];
   assign rcmd_addr      = {1'b0, cmd.addr[ADDR_WR_BIT-1:0]};
   assign rcmd_data      = cmd.data;
   assign udp_cmd_addr   = cmd.addr;
   assign tmo_reply_dv   = tmo_hit;
   assign tmo_reply_data = tmo_hit ? TMO_WORD : '0;

`ifdef SRU_DCS_CMD_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYCLES);
   logic [TW-1:0] tmo_ctr;

   // A reply on the terminal-count cycle takes priority over the timeout.
   assign tmo_hit = (state == ST_WAIT) && !rcmd_reply_dv &&
                    (tmo_ctr == TW'(TMO_CYCLES-1));

   always_ff @(posedge dcsclk) begin
      if (reset || state == ST_ISSUE) tmo_ctr <= '0;
      else if (state == ST_WAIT)      tmo_ctr <= tmo_ctr + 1'b1;
   end

   always_ff @(posedge dcsclk) begin
      if (reset)                          tmo_cnt <= '0;
      else if (tmo_hit && tmo_cnt != '1)  tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
   assign tmo_cnt = '0;
`endif

   always_ff @(posedge dcsclk) begin
      if (reset) dcs_cmd_ovf <= 1'b0;
      else if (dcs_cmd_dv && dcs_cmd_full) dcs_cmd_ovf <= 1'b1;
   end

   always_ff @(posedge dcsclk) begin
      if (reset) begin
         state      <= ST_IDLE;
         hold_first <= 1'b0;
         cmd        <= '0;
         cmd_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (!fifo_empty) begin
               cmd   <= dcs_cmd_t'(fifo_rdata);
               state <= ST_ISSUE;
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: if (rcmd_reply_dv) begin
               cmd_cnt    <= cmd_cnt + 1'b1;
               hold_first <= 1'b1;
               state      <= ST_HOLD;
            end else if (tmo_hit) begin
               hold_first <= 1'b1;
               state      <= ST_HOLD;
            end
            default: begin
               // at least two HOLD cycles, longer while the reply is held
               hold_first <= 1'b0;
               if (!hold_first && !rcmd_reply_dv) state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_srudcscmdissue.sv
// Bench for srudcscmdissue: directed test-plan scenarios plus random traffic,
// checked cycle by cycle against a transaction-level queue model.
module tb_srudcscmdissue;
   import srudcs_pkg::*;

   localparam int TMO = 16;
`ifdef SRU_DCS_CMD_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        dcsclk = 1'b0;
   logic        reset, dcs_cmd_dv, rcmd_reply_dv;
   logic [63:0] dcs_cmd_word;
   logic        dcs_cmd_full, dcs_cmd_ovf, rcmd_exec, rcmd_wr, tmo_reply_dv;
   logic [31:0] rcmd_addr, rcmd_data, udp_cmd_addr, tmo_reply_data;
   logic [15:0] cmd_cnt;
   logic [7:0]  tmo_cnt;

   srudcscmdissue #(.QAW(2), .TMO_CYCLES(TMO)) dut (
      .dcsclk(dcsclk), .reset(reset),
      .dcs_cmd_dv(dcs_cmd_dv), .dcs_cmd_word(dcs_cmd_word),
      .dcs_cmd_full(dcs_cmd_full), .dcs_cmd_ovf(dcs_cmd_ovf),
      .rcmd_exec(rcmd_exec), .rcmd_wr(rcmd_wr), .rcmd_addr(rcmd_addr),
      .rcmd_data(rcmd_data), .rcmd_reply_dv(rcmd_reply_dv),
      .udp_cmd_addr(udp_cmd_addr), .tmo_reply_dv(tmo_reply_dv),
      .tmo_reply_data(tmo_reply_data), .cmd_cnt(cmd_cnt), .tmo_cnt(tmo_cnt)
   );

   always #5 dcsclk = ~dcsclk;

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: command queue plus the phase of the in-flight command
   typedef enum int {M_IDLE, M_ISSUE, M_WAIT, M_HOLD} mph_t;
   logic [63:0] mq[$];
   logic [63:0] mcur;
   mph_t        mph;
   int          mwait, mhold, mcmd, mtmo;
   bit          movf;

   // auto-responder and observation bookkeeping
   bit          auto_en, rand_rep;
   int          d_delay, d_len, sched, rlen, rl_cnt;
   int          cyc, t_exec, exec_gap, last_gap, n_exec, n_tmo;
   logic        last_wr;
   logic [31:0] last_addr, last_data, last_udp;

   task automatic model_reset();
      mq.delete();
      mcur = '0; mph = M_IDLE; mwait = 0; mhold = 0;
      mcmd = 0; mtmo = 0; movf = 1'b0;
      sched = 0; rl_cnt = 0;
   endtask

   task automatic cycle(input bit dv, input logic [63:0] w, input bit stray);
      bit rep, tmo_e, full_now;
      if (sched > 0) begin
         sched--;
         if (sched == 0) rl_cnt = rlen;
      end
      rep = stray || (rl_cnt > 0);
      if (rl_cnt > 0) rl_cnt--;
      @(negedge dcsclk);
      dcs_cmd_dv = dv; dcs_cmd_word = w; rcmd_reply_dv = rep;
      #1;
      cyc++;
      tmo_e = TMO_EN && mph == M_WAIT && !rep && mwait == TMO-1;
      full_now = (mq.size() == 4);
      chk("exec", 64'(rcmd_exec), 64'(mph == M_ISSUE));
      chk("full", 64'(dcs_cmd_full), 64'(full_now));
      chk("ovf", 64'(dcs_cmd_ovf), 64'(movf));
      chk("tmo_dv", 64'(tmo_reply_dv), 64'(tmo_e));
      chk("tmo_data", 64'(tmo_reply_data), tmo_e ? 64'(TMO_WORD_DEF) : 64'h0);
      chk("cmd_cnt", 64'(cmd_cnt), 64'(mcmd % 65536));
      chk("tmo_cnt", 64'(tmo_cnt), 64'(mtmo));
      if (mph != M_IDLE) begin
         chk("rcmd_wr", 64'(rcmd_wr), 64'(mcur[63]));
         chk("rcmd_addr", 64'(rcmd_addr), {33'h0, mcur[62:32]});
         chk("rcmd_data", 64'(rcmd_data), 64'(mcur[31:0]));
         chk("udp_addr", 64'(udp_cmd_addr), 64'(mcur[63:32]));
      end
      if (rcmd_exec === 1'b1) begin
         last_wr = rcmd_wr; last_addr = rcmd_addr;
         last_data = rcmd_data; last_udp = udp_cmd_addr;
         exec_gap = cyc - t_exec; t_exec = cyc; n_exec++;
      end
      if (tmo_reply_dv === 1'b1) begin
         n_tmo++; last_gap = cyc - t_exec;
      end
      // advance the model across the coming edge
      if (dv && full_now) movf = 1'b1;
      case (mph)
         M_IDLE: if (mq.size() > 0) begin mcur = mq.pop_front(); mph = M_ISSUE; end
         M_ISSUE: begin
            mph = M_WAIT; mwait = 0;
            if (auto_en) begin
               sched = rand_rep ? int'($urandom_range(1, 20)) : d_delay;
               rlen  = rand_rep ? int'($urandom_range(1, 5))  : d_len;
            end
         end
         M_WAIT: begin
            if (rep) begin mcmd++; mph = M_HOLD; mhold = 0; end
            else if (tmo_e) begin if (mtmo < 255) mtmo++; mph = M_HOLD; mhold = 0; end
            else mwait++;
         end
         M_HOLD: begin
            if (mhold >= 1 && !rep) mph = M_IDLE;
            mhold++;
         end
      endcase
      if (dv && !full_now) mq.push_back(w);
   endtask

   task automatic do_reset();
      @(negedge dcsclk);
      reset = 1'b1; dcs_cmd_dv = 1'b0; rcmd_reply_dv = 1'b0;
      @(negedge dcsclk);
      #1;
      chk("rst_exec", 64'(rcmd_exec), 64'h0);
      chk("rst_full", 64'(dcs_cmd_full), 64'h0);
      chk("rst_ovf", 64'(dcs_cmd_ovf), 64'h0);
      chk("rst_addr", 64'(rcmd_addr), 64'h0);
      chk("rst_udp", 64'(udp_cmd_addr), 64'h0);
      chk("rst_cmdcnt", 64'(cmd_cnt), 64'h0);
      chk("rst_tmocnt", 64'(tmo_cnt), 64'h0);
      chk("rst_tmodv", 64'(tmo_reply_dv), 64'h0);
      model_reset();
      reset = 1'b0;
   endtask

   initial begin
      int e0, t0;
      reset = 1'b1; dcs_cmd_dv = 1'b0; rcmd_reply_dv = 1'b0; dcs_cmd_word = '0;
      auto_en = 1'b0; rand_rep = 1'b0; d_delay = 1; d_len = 1;
      cyc = 0; t_exec = 0; exec_gap = 0; last_gap = 0; n_exec = 0; n_tmo = 0;
      model_reset();
      repeat (2) @(negedge dcsclk);
      do_reset();

      // single read, reply 3 cycles after issue
      auto_en = 1'b1; d_delay = 3; d_len = 1;
      cycle(1'b1, 64'h0000_0010_0000_0000, 1'b0);
      repeat (12) cycle(1'b0, '0, 1'b0);
      chk("rd_addr", 64'(last_addr), 64'h10);
      chk("rd_wr", 64'(last_wr), 64'h0);
      chk("rd_udp", 64'(last_udp), 64'h10);
      chk("rd_cnt", 64'(cmd_cnt), 64'h1);

      // write
      cycle(1'b1, 64'h8000_0020_1234_5678, 1'b0);
      repeat (12) cycle(1'b0, '0, 1'b0);
      chk("wr_wr", 64'(last_wr), 64'h1);
      chk("wr_addr", 64'(last_addr), 64'h20);
      chk("wr_data", 64'(last_data), 64'h1234_5678);
      chk("wr_udp", 64'(last_udp), 64'h8000_0020);

      // overflow: six back-to-back pushes, no replies
      auto_en = 1'b0; e0 = n_exec;
      for (int i = 0; i < 6; i++) cycle(1'b1, {32'h100 + i, 32'hA0 + i}, 1'b0);
      cycle(1'b0, '0, 1'b0);
      chk("ovf_full", 64'(dcs_cmd_full), 64'h1);
      chk("ovf_flag", 64'(dcs_cmd_ovf), 64'h1);
      auto_en = 1'b1; d_delay = 2; d_len = 1;
      cycle(1'b0, '0, 1'b1);
      repeat (50) cycle(1'b0, '0, 1'b0);
      chk("ovf_issued", 64'(n_exec - e0), 64'd5);
      chk("ovf_last", 64'(last_addr), 64'h104);

      // timeout: two commands, no replies
      auto_en = 1'b0; e0 = n_exec; t0 = n_tmo; last_gap = 0;
      cycle(1'b1, 64'h0000_0030_0000_0000, 1'b0);
      cycle(1'b1, 64'h0000_0031_0000_0000, 1'b0);
      repeat (24) cycle(1'b0, '0, 1'b0);
      chk("tmo_seen", 64'(n_tmo - t0), TMO_EN ? 64'd1 : 64'd0);
      chk("tmo_gap", 64'(last_gap), TMO_EN ? 64'd16 : 64'd0);
      chk("tmo_cntv", 64'(tmo_cnt), TMO_EN ? 64'd1 : 64'd0);
      chk("tmo_next", 64'(n_exec - e0), TMO_EN ? 64'd2 : 64'd1);

      // reset during WAIT with a command still queued
      cycle(1'b1, 64'h0000_0032_0000_0000, 1'b0);
      do_reset();
      e0 = n_exec; t0 = n_tmo;
      repeat (3) cycle(1'b0, '0, 1'b1);
      repeat (25) cycle(1'b0, '0, 1'b0);
      chk("rstw_exec", 64'(n_exec - e0), 64'd0);
      chk("rstw_tmo", 64'(n_tmo - t0), 64'd0);
      chk("rstw_cnt", 64'(cmd_cnt), 64'd0);

      // reply exactly on the terminal count
      auto_en = 1'b1; d_delay = TMO; d_len = 1; t0 = n_tmo;
      cycle(1'b1, 64'h0000_0040_0000_0001, 1'b0);
      repeat (30) cycle(1'b0, '0, 1'b0);
      chk("tc_cnt", 64'(cmd_cnt), 64'd1);
      chk("tc_notmo", 64'(n_tmo - t0), 64'd0);

      // reply held five cycles stretches HOLD, no re-issue
      d_delay = 2; d_len = 5; e0 = n_exec;
      cycle(1'b1, 64'h0000_0050_0000_0000, 1'b0);
      cycle(1'b1, 64'h0000_0051_0000_0000, 1'b0);
      repeat (30) cycle(1'b0, '0, 1'b0);
      chk("hold_gap", 64'(exec_gap), 64'd9);
      chk("hold_issued", 64'(n_exec - e0), 64'd2);
      chk("hold_cnt", 64'(cmd_cnt), 64'd3);

      // minimum back-to-back spacing
      d_delay = 1; d_len = 1;
      cycle(1'b1, 64'h0000_0060_0000_0000, 1'b0);
      cycle(1'b1, 64'h0000_0061_0000_0000, 1'b0);
      repeat (15) cycle(1'b0, '0, 1'b0);
      chk("min_gap", 64'(exec_gap), 64'd5);

      // random traffic with random reply timing and stray strobes
      rand_rep = 1'b1;
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 3) == 0, {$urandom, $urandom}, $urandom_range(0, 31) == 0);
      repeat (80) cycle(1'b0, '0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
      $fatal(1);
   end

endmodule

// File: doc/srudcscmdissue.md
Name: srudcscmdissue

Overview:
- DCS-side command initiator for the SRU register/readout command path.
- Accepts 64-bit DCS command words {addr,data}, queues them and issues one command at a time to the remote command executor.
- Waits for the executor's reply strobe, holding `udp_cmd_addr` stable so the downstream reply/ack formatter can pair the address with the returned data.
- Generates a synthetic error reply when the executor does not answer in time.

Parameters:
- QAW, 2, log2 of command queue depth (depth = 2^QAW = 4).
- TMO_CYCLES, 4096, dcsclk cycles to wait for `rcmd_reply_dv` before timeout (≥4).
- TMO_WORD, 32'hDEAD_0BAD, data value reported on timeout.

Ports:
- dcsclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dcs_cmd_dv  in  1  one-cycle strobe: `dcs_cmd_word` valid
- dcs_cmd_word  in  64  [63:32] address (bit63 = 1 write, 0 read), [31:0] write data
- dcs_cmd_full  out  1  queue full (registered)
- dcs_cmd_ovf  out  1  sticky: command dropped on full queue
- rcmd_exec  out  1  one-cycle issue strobe to executor
- rcmd_wr  out  1  write flag of issued command
- rcmd_addr  out  32  issued address, bit31 cleared
- rcmd_data  out  32  issued write data
- rcmd_reply_dv  in  1  executor reply strobe (may be held high several cycles)
- udp_cmd_addr  out  32  full address of the in-flight command (bit31 preserved)
- tmo_reply_dv  out  1  one-cycle synthetic reply strobe on timeout
- tmo_reply_data  out  32  equals TMO_WORD while `tmo_reply_dv` is high, else 0
- cmd_cnt  out  16  completed commands, wraps
- tmo_cnt  out  8  timeouts, saturates at 255

Behaviour:
- Reset values:
  - All outputs are 0.
  - Queue is emptied and the FSM enters IDLE.
  - `dcs_cmd_ovf` is cleared.
  - Reset mid-command abandons the command; no reply or timeout strobe is generated afterwards.
- Queue:
  - FIFO of 2^QAW x 64.
  - Push on `dcs_cmd_dv` when not full.
  - `dcs_cmd_full` is derived from the registered occupancy.
  - Push while full is dropped and sets `dcs_cmd_ovf`, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves occupancy unchanged.
  - Pointers wrap modulo 2^QAW.
- FSM:
  - IDLE: if the queue is non-empty, pop the head into the command register, go to ISSUE.
  - ISSUE (1 cycle):
    - `rcmd_exec` = 1.
    - `rcmd_wr` = addr[63].
    - `rcmd_addr` = {1'b0, addr[62:32]}.
    - `rcmd_data` = data.
    - `udp_cmd_addr` = addr[63:32].
    - Clear the timeout counter; go to WAIT.
  - WAIT:
    - On `rcmd_reply_dv`: go to HOLD and increment `cmd_cnt`.
    - Else, when the counter reaches TMO_CYCLES-1: pulse `tmo_reply_dv` for 1 cycle with `tmo_reply_data` = TMO_WORD, increment `tmo_cnt` (saturating), go to HOLD.
    - Else increment the counter.
    - If `rcmd_reply_dv` arrives in the same cycle as the terminal count, the reply wins: no timeout.
  - HOLD:
    - Stay for at least 2 cycles.
    - Stay while `rcmd_reply_dv` = 1.
    - Then go to IDLE.
- `udp_cmd_addr` and `rcmd_*` stay stable from ISSUE until leaving HOLD. This guarantees the ack formatter samples the correct address one cycle after the reply strobe.
- Back-to-back commands: minimum spacing is 5 cycles (ISSUE, WAIT ≥1, HOLD ≥2, IDLE).
- A `rcmd_reply_dv` pulse seen in IDLE or ISSUE is ignored.

Optional Feature:
- Macro: SRU_DCS_CMD_TIMEOUT_EN.
- Defined: timeout logic as above.
- Undefined:
  - WAIT waits indefinitely.
  - `tmo_reply_dv`, `tmo_reply_data` and `tmo_cnt` are tied to 0.
  - The timeout counter is not synthesized.

Decomposition:
- Shared package srudcs_pkg:
  - FSM state encoding (IDLE = 0, ISSUE = 1, WAIT = 2, HOLD = 3).
  - Address write-bit index (31).
  - TMO_WORD default.
  - Command-word field offsets.
- One sub-module: srudcscmdfifo (synchronous FIFO with full/empty, parameter QAW).

Test Plan:
- Single read: push 64'h0000_0010_0000_0000, reply after 3 cycles → `rcmd_exec` pulse, `rcmd_wr` = 0, `rcmd_addr` = 32'h10, `udp_cmd_addr` = 32'h10 stable through HOLD, `cmd_cnt` = 1.
- Write: push 64'h8000_0020_1234_5678 → `rcmd_wr` = 1, `rcmd_addr` = 32'h20, `rcmd_data` = 32'h12345678, `udp_cmd_addr` = 32'h8000_0020.
- Overflow: 6 pushes on consecutive cycles with no replies → after the first pop, 4 queued, 1 dropped, `dcs_cmd_full` = 1, `dcs_cmd_ovf` = 1; issue order matches push order.
- Timeout: no reply (TMO_CYCLES = 16 in bench) → `tmo_reply_dv` pulse exactly 16 cycles after ISSUE, `tmo_reply_data` = 32'hDEAD_0BAD, `tmo_cnt` = 1, next command issued.
- Boundary:
  - Reply coinciding with the terminal count → no timeout, `cmd_cnt` increments.
  - Reply held high 5 cycles → HOLD lasts 5 cycles, no re-issue.
- Reset during WAIT → all outputs 0, queue empty, no late strobe after reply arrives.
